// File: rtl/serial_pkg.sv
// Shared constants for the serial receiver/transmitter family: FSM state
// encoding, parity-mode selectors and the parity check helper.
package serial_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Returns 1 when the received parity bit disagrees with the data word.
    // data_xor is the reduction XOR of the data bits.
    function automatic logic parity_error(input int mode, input logic data_xor,
                                          input logic par_bit);
        logic err;
        err = 1'b0;
        if (mode == PAR_EVEN) begin
            err = data_xor ^ par_bit;
        end else if (mode == PAR_ODD) begin
            err = ~(data_xor ^ par_bit);
        end
        return err;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer. After restart it raises mid_tick once after
// CLKS_PER_BIT/2 enabled cycles (middle of the start bit) and then once every
// CLKS_PER_BIT enabled cycles (middle of each following bit).
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic mid_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;
    logic          first_half;

    // The counter is cleared on every tick, so it never wraps inside a bit.
    assign mid_tick = enable && !restart &&
                      (cnt == (first_half ? HALF_LAST : FULL_LAST));

    // Cycle counter: half period first, full periods afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            first_half <= 1'b1;
        end else if (restart) begin
            cnt        <= '0;
            first_half <= 1'b1;
        end else if (enable) begin
            if (mid_tick) begin
                cnt        <= '0;
                first_half <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_rx_param.sv
// Parameterised asynchronous serial receiver: start/data/parity/stop framing,
// mid-bit sampling, held output word with valid/ready handover and overrun.
//
// Output handshake: a word transfers on any clk edge where data_valid and
// data_ready are both high. While data_valid=1 and data_ready=0, data_out,
// parity_err and frame_err hold. A frame finishing while the word is held and
// not being accepted is dropped and overrun pulses for one cycle; a frame
// finishing on the accepting edge replaces the word and data_valid stays high.
module serial_rx_param
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_enable,
    input  logic              serial_in,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              rx_busy,
    output logic [2:0]        state_dbg
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic [1:0]        sync;
    logic              line;
    logic [2:0]        state;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_acc;
    logic              stop_acc;
    logic              mid_tick;
    logic              deliver;

    assign line      = sync[1];
    assign rx_busy   = (state != ST_IDLE);
    assign state_dbg = state;

    // Last stop sample of a frame that is still enabled.
    assign deliver = rx_enable && (state == ST_STOP) && mid_tick &&
                     (bit_cnt == LAST_STOP);

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], serial_in};
        end
    end

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .restart  ((state == ST_IDLE) || !rx_enable),
        .enable   (state != ST_IDLE),
        .mid_tick (mid_tick)
    );

    // Frame FSM with data shift register and per-frame error accumulators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            stop_acc <= 1'b0;
        end else if (!rx_enable) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!line) begin
                        state    <= ST_START;
                        bit_cnt  <= '0;
                        par_acc  <= 1'b0;
                        stop_acc <= 1'b0;
                    end
                end
                ST_START: begin
                    // A high line at the start mid-point was only a glitch.
                    if (mid_tick) begin
                        state <= line ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid_tick) begin
                        shreg <= {line, shreg[DATA_W-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (mid_tick) begin
                        par_acc <= parity_error(PARITY, ^shreg, line);
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (mid_tick) begin
                        stop_acc <= stop_acc | ~line;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Held output word, flags, valid/ready handover and overrun pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver && (!data_valid || data_ready)) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                parity_err <= par_acc;
                frame_err  <= stop_acc | ~line;
            end else begin
                if (deliver) begin
                    overrun <= 1'b1;
                end
                if (data_ready) begin
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/serial_rx_param.md
SERIAL_RX_PARAM -- requirements
Module: serial_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per bit period, legal minimum 4.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame, legal values 1 or 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx_enable  input  1  receiver enable; low aborts and holds the receiver idle.
REQ-008 SHALL have port serial_in  input  1  asynchronous serial line, idle high, LSB first.
REQ-009 SHALL have port data_ready  input  1  consumer accepts the held word.
REQ-010 SHALL have port data_out  output  DATA_W  received word.
REQ-011 SHALL have port data_valid  output  1  data_out and its error flags are valid.
REQ-012 SHALL have port parity_err  output  1  parity mismatch on the held word.
REQ-013 SHALL have port frame_err  output  1  a stop bit sampled low on the held word.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse: a completed frame was dropped.
REQ-015 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL pass serial_in through a 2-flop synchroniser (reset value 1) before any use.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, PAR, STOP.
REQ-018 IDLE -> START when rx_enable=1 and the synchronised line = 0; bit counter and cycle counter cleared.
REQ-019 START: sample at cycle CLKS_PER_BIT/2; a 0 goes to DATA, and a 1 is treated as a glitch and returns to IDLE with no flags set.
REQ-020 DATA: sample every CLKS_PER_BIT cycles after the start mid-point, shift LSB first, and after DATA_W samples go to PAR (PARITY!=0) or STOP.
REQ-021 PAR: sample one bit; for even parity, parity_err = XOR(data, bit); for odd parity, parity_err = ~XOR(data, bit).
REQ-022 STOP: sample STOP_BITS bits; frame_err = 1 if any sampled stop bit is 0.
REQ-023 At the final stop sample, SHALL go to IDLE and deliver the word plus flags, with data_valid set on the next clk edge.
REQ-024 A frame with errors SHALL still be delivered, with its flags set.
REQ-025 data_valid SHALL stay high, with data_out and flags stable, until a cycle with data_ready=1.
REQ-026 A frame completing while data_valid=1 and data_ready=0 SHALL be dropped; overrun pulses 1 cycle and the held word is unchanged.
REQ-027 A frame completing in the same cycle as acceptance SHALL load the new word; data_valid stays 1 and no overrun occurs.
REQ-028 rx_enable=0 SHALL force IDLE on the next edge and discard the partial frame; data_valid and the held word are unaffected.
REQ-029 Counters SHALL be sized $clog2(CLKS_PER_BIT) and $clog2(DATA_W+1), and SHALL never wrap mid-bit.

Reset
REQ-030 reset_n=0 SHALL immediately force: IDLE; counters 0; data_out 0; data_valid, parity_err, frame_err, overrun, rx_busy all 0; synchroniser 1.
REQ-031 Reset asserted mid-frame SHALL discard the frame, and the first frame after release SHALL be received normally.

Structure
REQ-032 State encoding and parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) SHALL live in the shared package serial_pkg.
REQ-033 Bit-period timing SHALL be a sub-module serial_bit_timer (params CLKS_PER_BIT; inputs restart and enable; output mid_tick), reusable by the transmitter.

Verification
REQ-034 DATA_W=8, CLKS_PER_BIT=16, PARITY=1, frame 0xA5 with parity bit 0 -> data_out=0xA5, parity_err=0, frame_err=0, data_valid 1 cycle after the stop mid-point.
REQ-035 Same configuration, 0xA5 with parity bit 1 -> data_out=0xA5, parity_err=1.
REQ-036 PARITY=0, 0x3C with stop bit 0 -> frame_err=1; next frame 0x55 with valid stop -> frame_err=0.
REQ-037 6-cycle low glitch on an idle line -> returns to IDLE, data_valid stays 0, rx_busy drops.
REQ-038 Frames 0x3C then 0xC3 with data_ready held 0 -> data_out stays 0x3C, one overrun pulse; data_ready on the completion edge of 0xC3 -> 0xC3 loaded, no overrun.
REQ-039 reset_n pulsed low mid-DATA, then frame 0x81 -> all outputs 0 during reset, then data_out=0x81 with no flags.
